reorder_buffer: RTL

- Circular in-order completion buffer sitting after the issue queue, reservation stations and CDB.
- The issue queue allocates one entry per issued instruction; the entry index is the ROB tag (rd_rob_tag) that travels with the reservation-station word.
- CDB broadcasts mark entries complete and capture their results. The head entry retires in program order to the register file.

---
 rtl/reorder_buffer.sv | 85 ++++++++
 1 files changed

// File: rtl/reorder_buffer.sv
// reorder_buffer: circular in-order completion buffer; optional operand read ports under ROB_FORWARD_EN
module reorder_buffer #(
    parameter int DEPTH  = 8,
    parameter int TAG_W  = 3,
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    alloc_valid,
    input  logic [REG_W-1:0]        alloc_rd,
    output logic [TAG_W-1:0]        alloc_tag,
    output logic                    rob_full,
    input  logic [DEPTH-1:0]        cdb_valid,
    input  logic [DEPTH*DATA_W-1:0] cdb_data,
    output logic [DEPTH-1:0]        robs_calculated,
    output logic                    commit_valid,
    output logic                    commit_we,
    output logic [REG_W-1:0]        commit_rd,
    output logic [DATA_W-1:0]       commit_data,
    output logic [TAG_W-1:0]        commit_tag,
`ifdef ROB_FORWARD_EN
    input  logic [TAG_W-1:0]        src1_tag,
    input  logic [TAG_W-1:0]        src2_tag,
    output logic                    src1_rob_rdy,
    output logic                    src2_rob_rdy,
    output logic [DATA_W-1:0]       src1_rob_data,
    output logic [DATA_W-1:0]       src2_rob_data,
`endif
    input  logic                    flush
);
    logic [DEPTH-1:0]  busy, done;
    logic [REG_W-1:0]  rd_q   [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [TAG_W-1:0]  head, tail;
    logic [TAG_W:0]    count;
    logic              alloc_ok;

    assign alloc_tag       = tail;
    assign rob_full        = count == (TAG_W+1)'(DEPTH);
    assign alloc_ok        = alloc_valid && !rob_full;
    assign robs_calculated = busy & done;
    assign commit_valid    = busy[head] && done[head];
    assign commit_rd       = rd_q[head];
    assign commit_data     = data_q[head];
    assign commit_tag      = head;
    assign commit_we       = commit_valid && commit_rd != '0;

`ifdef ROB_FORWARD_EN
    assign src1_rob_rdy  = busy[src1_tag] && done[src1_tag];
    assign src2_rob_rdy  = busy[src2_tag] && done[src2_tag];
    assign src1_rob_data = data_q[src1_tag];
    assign src2_rob_data = data_q[src2_tag];
`endif

    // entry state and pointers: reset/flush clear, else CDB capture, retire head, allocate tail (alloc last so it wins)
    always_ff @(posedge clk) begin
        if (!reset_n || flush) begin
            busy  <= '0;
            done  <= '0;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++)
                if (cdb_valid[i] && busy[i]) begin
                    done[i]   <= 1'b1;
                    data_q[i] <= cdb_data[i*DATA_W +: DATA_W];
                end
            if (commit_valid) begin
                busy[head] <= 1'b0;
                done[head] <= 1'b0;
                head       <= head + 1'b1;
            end
            if (alloc_ok) begin
                busy[tail] <= 1'b1;
                done[tail] <= 1'b0;
                rd_q[tail] <= alloc_rd;
                tail       <= tail + 1'b1;
            end
            count <= (alloc_ok && !commit_valid) ? count + 1'b1 :
                     (!alloc_ok && commit_valid) ? count - 1'b1 : count;
        end
    end
endmodule
